// File: rtl/ram_arb_pkg.sv
// Shared types and sizes for the two-port RAM arbiter and its RAM.
package ram_arb_pkg;

    localparam int RAM_AW = 5;
    localparam int RAM_DW = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/big_ram.sv
// Single-port 32 x 8 RAM with a registered read word.
// The whole array clears when rst and cs are both high on a clock edge.
module BIG_RAM
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wrt,
    input  logic              rd,
    input  logic [RAM_AW-1:0] addr,
    input  logic [RAM_DW-1:0] wdata,
    output logic [RAM_DW-1:0] rdata
);

    localparam int DEPTH = 1 << RAM_AW;

    logic [RAM_DW-1:0] mem_q [DEPTH];
    logic [RAM_DW-1:0] rdata_q;

    // Array and read word update only while selected
    always_ff @(posedge clk) begin
        if (cs) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
                rdata_q <= '0;
            end else if (wrt) begin
                mem_q[addr] <= wdata;
            end else if (rd) begin
                rdata_q <= mem_q[addr];
            end else begin
                rdata_q <= rdata_q;
            end
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker; masked requests are ignored and a tie
// goes to the port that did not win last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] mask,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic [1:0] eff_s;

    // Resolve the effective request vector to a single winner
    always_comb begin
        eff_s     = req & ~mask;
        gnt_valid = |eff_s;
        case (eff_s)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two req/ack ports with round-robin
// arbitration, sequencing the RAM strobes and returning read data on ack.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          ram_rst,
    output logic          ram_cs,
    output logic          ram_wrt,
    output logic          ram_rd,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic [1:0]    arb_mask_s;
    logic          gnt_valid_s;
    logic          gnt_id_s;
    logic          in_access_s;
    logic          in_resp_s;

    // In RESP the port being acked must not win again this cycle
    assign arb_mask_s = (state_q == S_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

    rr_arb2 u_arb (
        .req       ({req1, req0}),
        .last      (last_q),
        .mask      (arb_mask_s),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    // Next-state, command latch and read-data capture
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_valid_s) begin
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (!we_q) begin
                    if (grant_q) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                end else begin
                    rdata0_d = rdata0_q;
                end
                if (gnt_valid_s) begin
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any new grant (from IDLE or RESP) latches the winner's command
        if ((state_q == S_IDLE || state_q == S_RESP) && gnt_valid_s) begin
            last_d  = gnt_id_s;
            grant_d = gnt_id_s;
            we_d    = gnt_id_s ? we1    : we0;
            addr_d  = gnt_id_s ? addr1  : addr0;
            wdata_d = gnt_id_s ? wdata1 : wdata0;
        end else begin
            last_d  = last_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign in_access_s = (state_q == S_ACCESS) && !rst;
    assign in_resp_s   = (state_q == S_RESP) && !rst;

    assign ram_rst   = rst;
    assign ram_cs    = rst | (state_q == S_ACCESS);
    assign ram_wrt   = in_access_s & we_q;
    assign ram_rd    = in_access_s & ~we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign ack0 = in_resp_s & ~grant_q;
    assign ack1 = in_resp_s & grant_q;

    // Read results bypass straight from the RAM during their ack cycle
    assign rdata0 = (ack0 && !we_q) ? ram_rdata : rdata0_q;
    assign rdata1 = (ack1 && !we_q) ? ram_rdata : rdata1_q;

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: ram_arbiter driving a BIG_RAM, checked cycle by cycle
// against hand-computed expectations.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic       ram_rst, ram_cs, ram_wrt, ram_rd;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .ram_rst   (ram_rst),
        .ram_cs    (ram_cs),
        .ram_wrt   (ram_wrt),
        .ram_rd    (ram_rd),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    BIG_RAM u_ram (
        .clk   (clk),
        .rst   (ram_rst),
        .cs    (ram_cs),
        .wrt   (ram_wrt),
        .rd    (ram_rd),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One uncontended access on a port, checking ACCESS, RESP and the idle cycle after
    task automatic do_single(input logic port, input logic we, input logic [4:0] a,
                             input logic [7:0] d, input logic [7:0] exp_rd,
                             input logic [7:0] exp_other);
        if (!port) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
        tick();
        check("acc_busy", busy, 32'd1);
        check("acc_cs", ram_cs, 32'd1);
        check("acc_wrt", ram_wrt, we);
        check("acc_rd", ram_rd, !we);
        check("acc_addr", ram_addr, a);
        check("acc_noack", ack0 | ack1, 32'd0);
        check("acc_other_rdata", port ? rdata0 : rdata1, exp_other);
        tick();
        check("resp_ack", port ? ack1 : ack0, 32'd1);
        check("resp_other_ack", port ? ack0 : ack1, 32'd0);
        check("resp_cs", ram_cs, 32'd0);
        if (!we) check("resp_rdata", port ? rdata1 : rdata0, exp_rd);
        check("resp_other_rdata", port ? rdata0 : rdata1, exp_other);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("idle_noack", ack0 | ack1, 32'd0);
        check("idle_busy", busy, 32'd0);
        if (!we) check("idle_rdata_held", port ? rdata1 : rdata0, exp_rd);
        check("idle_other_rdata", port ? rdata0 : rdata1, exp_other);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_cs", ram_cs, 32'd1);
        check("rst_ram_rst", ram_rst, 32'd1);
        tick();
        check("rst_busy", busy, 32'd0);
        check("rst_ack", ack0 | ack1, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_cs", ram_cs, 32'd0);
        check("post_rst_ram_rst", ram_rst, 32'd0);
        check("post_rst_rdata0", rdata0, 32'd0);
        check("post_rst_rdata1", rdata1, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 5'd0; addr1 = 5'd0; wdata0 = 8'd0; wdata1 = 8'd0;
        do_reset();

        // Preload 0x1B with a nonzero value, then reset must wipe it
        do_single(1'b0, 1'b1, 5'h1B, 8'h5A, 8'h00, 8'h00);
        do_single(1'b0, 1'b0, 5'h1B, 8'h00, 8'h5A, 8'h00);
        do_reset();
        do_single(1'b0, 1'b0, 5'h1B, 8'h00, 8'h00, 8'h00);

        // Port 0 write then read back; port 1 data untouched
        do_single(1'b0, 1'b1, 5'h1B, 8'h24, 8'h00, 8'h00);
        do_single(1'b0, 1'b0, 5'h1B, 8'h00, 8'h24, 8'h00);

        // Simultaneous requests after reset: port 0 first, port 1 right after
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h0A; wdata0 = 8'h36;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h0A; wdata1 = 8'h00;
        tick();
        check("tie_acc_wrt", ram_wrt, 32'd1);
        check("tie_acc_addr", ram_addr, 32'h0A);
        check("tie_acc_wdata", ram_wdata, 32'h36);
        check("tie_acc_noack", ack0 | ack1, 32'd0);
        tick();
        check("tie_ack0", ack0, 32'd1);
        check("tie_ack1_low", ack1, 32'd0);
        req0 = 1'b0;
        tick();
        check("tie2_acc_rd", ram_rd, 32'd1);
        check("tie2_noack", ack0 | ack1, 32'd0);
        check("tie2_busy", busy, 32'd1);
        tick();
        check("tie2_ack1", ack1, 32'd1);
        check("tie2_ack0_low", ack0, 32'd0);
        check("tie2_rdata1", rdata1, 32'h36);
        req1 = 1'b0;
        tick();
        check("tie2_idle", busy, 32'd0);
        check("tie2_rdata1_held", rdata1, 32'h36);

        // Both ports requesting continuously: ACCESS/RESP ping-pong
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h0A;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h1B;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("pp_acc_noack", ack0 | ack1, 32'd0);
            check("pp_acc_busy", busy, 32'd1);
            tick();
            check("pp_ack0", ack0, (i % 2) == 0);
            check("pp_ack1", ack1, (i % 2) == 1);
            check("pp_resp_busy", busy, 32'd1);
            if ((i % 2) == 0) check("pp_rdata0", rdata0, 32'h36);
            else check("pp_rdata1", rdata1, 32'h00);
            if (i == 7) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        tick();
        check("pp_end_idle", busy, 32'd0);

        // Reset during ACCESS of a write abandons it and clears the RAM
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h1B; wdata0 = 8'h68;
        tick();
        check("rstacc_wrt", ram_wrt, 32'd1);
        rst = 1'b1;
        check("rstacc_cs", ram_cs, 32'd1);
        check("rstacc_ram_rst", ram_rst, 32'd1);
        req0 = 1'b0;
        tick();
        check("rstacc_noack", ack0 | ack1, 32'd0);
        check("rstacc_busy", busy, 32'd0);
        rst = 1'b0;
        tick();
        check("rstacc_idle_noack", ack0 | ack1, 32'd0);
        do_single(1'b0, 1'b0, 5'h1B, 8'h00, 8'h00, 8'h00);

        // Port 1 read result survives a port 0 write to the same word
        do_single(1'b0, 1'b1, 5'h0A, 8'h36, 8'h00, 8'h00);
        do_single(1'b1, 1'b0, 5'h0A, 8'h00, 8'h36, 8'h00);
        do_single(1'b0, 1'b1, 5'h0A, 8'h11, 8'h00, 8'h36);
        do_single(1'b1, 1'b0, 5'h0A, 8'h00, 8'h11, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
